uart_cmd_parser: RTL
====================

Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART receiver and consumes its byte stream (`dout`, `valid`, `parity_error`).
- Assembles fixed-format command frames into EEPROM read/write requests.
- Presents each request to the IIC EEPROM controller over a valid/ready handshake.
- Malformed or stalled frames are discarded with a one-cycle error pulse and a code.

Parameters:
- BYTE_SIZE, 8, width of received bytes and of write data.
- HEADER, 8'h55, frame start byte.
- CMD_WR, 8'h01, command byte for a write request.
- CMD_RD, 8'h02, command byte for a read request.
- TIMEOUT_CYCLES, 500000, maximum idle clocks between consecutive bytes inside one frame.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- rx_data  input  BYTE_SIZE  received byte from the UART receiver
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle
- rx_parity_err  input  1  parity error flag for the byte strobed this cycle
- req_valid  output  1  request pending to the EEPROM controller
- req_we  output  1  1 = write, 0 = read
- req_addr  output  16  EEPROM byte address
- req_wdata  output  BYTE_SIZE  write data; 0 for reads
- req_ready  input  1  controller accepts the request
- frame_err  output  1  one-cycle pulse, frame aborted
- err_code  output  2  abort cause: 0 timeout, 1 parity, 2 bad command, 3 checksum; held until the next abort
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock (clk); synchronous active-high reset (rst), sampled on the rising edge of clk.
- Reset values: all outputs 0; state IDLE; timeout counter and checksum accumulator 0.
- Reset mid-frame or mid-handshake: abandons everything; no request is issued and no frame_err pulse is generated.
- Frame format: HEADER, CMD, ADDR_H, ADDR_L, DATA (write only), CHK.
  - CHK = XOR of CMD, ADDR_H, ADDR_L and DATA (write only).
- State sequence: IDLE -> CMD -> ADDR_H -> ADDR_L -> [DATA] -> CHK -> ISSUE -> IDLE. Each transition on rx_valid only.
- IDLE:
  - Byte == HEADER with no parity error -> CMD; clear the accumulator.
  - Any other byte, including a byte with a parity error, is ignored silently.
- CMD:
  - CMD_WR sets the internal write flag; CMD_RD clears it.
  - Any other value -> abort, code 2.
  - CMD is XORed into the accumulator.
- ADDR_H / ADDR_L: load the upper / lower address byte and XOR it into the accumulator.
  - After ADDR_L: go to DATA if write, else CHK.
- DATA: load the write data and XOR it into the accumulator.
- CHK:
  - Received byte equal to the accumulator -> ISSUE.
  - Otherwise abort, code 3.
- Parity errors: rx_parity_err on any byte in CMD..CHK -> abort, code 1. Parity takes priority over the command and checksum checks.
- Abort: next state IDLE; frame_err = 1 for exactly one cycle; err_code updated in the same cycle.
- Timeout:
  - Counter clears on every rx_valid and counts in CMD..CHK.
  - Reaching TIMEOUT_CYCLES-1 without a byte -> abort, code 0.
  - Same-cycle rx_valid wins over the timeout.
- ISSUE:
  - req_valid is registered high the cycle after the rx_valid of the CHK byte (latency 1).
  - req_we, req_addr and req_wdata are stable while req_valid is high.
  - On req_valid && req_ready: req_valid deasserts next cycle and the state returns to IDLE.
  - If req_ready is already high on the first ISSUE cycle, req_valid is high for exactly one cycle.
- Bytes received in ISSUE are dropped without error. The next frame must begin with HEADER after the return to IDLE.
- No timeout in IDLE or ISSUE; ISSUE waits indefinitely for req_ready.
- Read requests drive req_wdata = 0.

Test Plan:
- Write frame: bytes 55 01 00 2A 5A 71 with req_ready=1 -> one-cycle req_valid with req_we=1, req_addr=0x002A, req_wdata=0x5A, one cycle after the 0x71 strobe; frame_err never asserts.
- Read frame with stall: bytes 55 02 12 34 24, req_ready low for 10 cycles, and byte 55 injected during the stall -> req_valid holds for 11 cycles with req_we=0, req_addr=0x1234, req_wdata=0. The injected byte is dropped; busy falls after the handshake.
- Bad checksum and bad command:
  - 55 02 12 34 25 -> frame_err pulse, err_code=3, no req_valid.
  - 55 07 -> frame_err pulse, err_code=2.
  - A following valid read frame is then parsed correctly.
- Parity and noise:
  - 55 01 00 with rx_parity_err set on 0x00 -> frame_err pulse, err_code=1.
  - Bytes AA 13 in IDLE -> no response.
  - 55 with parity error in IDLE -> ignored.
- Timeout with TIMEOUT_CYCLES=100: send 55 02 12, then wait 100 cycles -> frame_err pulse, err_code=0, state IDLE.
  - A gap of 98 cycles between bytes does not abort.
- Reset mid-frame: send 55 01 00, assert rst for one cycle, then send 2A 5A 71 -> no request and no frame_err.
  - A subsequent full write frame produces its request normally.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//
// Turns the UART receiver byte stream into EEPROM read/write requests.
// Frame layout: HEADER, CMD, ADDR_H, ADDR_L, [DATA for writes], CHK.
// CHK is the XOR of every byte between HEADER and CHK.
// A malformed, corrupted or stalled frame is dropped. The drop raises
// frame_err for one cycle and loads the cause into err_code.
//
// Handshake (req_*): req_valid rises one cycle after the CHK byte is
// accepted. While req_valid is high, req_we, req_addr and req_wdata do not
// change. A transfer happens on any clock edge where req_valid and
// req_ready are both high. req_valid drops on the following cycle and the
// parser returns to IDLE. req_valid never drops before that transfer.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   rx_data        received byte (BYTE_SIZE bits)
//   rx_valid       one-cycle strobe qualifying rx_data
//   rx_parity_err  parity error for the byte strobed this cycle
//   req_valid      request pending to the EEPROM controller
//   req_we         1 = write, 0 = read
//   req_addr       16-bit EEPROM byte address
//   req_wdata      write data (0 for reads)
//   req_ready      controller accepts the request
//   frame_err      one-cycle abort pulse
//   err_code       abort cause: 0 timeout, 1 parity, 2 bad command,
//                  3 checksum; holds its value until the next abort
//   busy           parser is in any state other than IDLE
module uart_cmd_parser #(
  parameter int                   BYTE_SIZE      = 8,
  parameter logic [BYTE_SIZE-1:0] HEADER         = 8'h55,
  parameter logic [BYTE_SIZE-1:0] CMD_WR         = 8'h01,
  parameter logic [BYTE_SIZE-1:0] CMD_RD         = 8'h02,
  parameter int                   TIMEOUT_CYCLES = 500000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BYTE_SIZE-1:0] rx_data,
  input  logic                 rx_valid,
  input  logic                 rx_parity_err,
  output logic                 req_valid,
  output logic                 req_we,
  output logic [15:0]          req_addr,
  output logic [BYTE_SIZE-1:0] req_wdata,
  input  logic                 req_ready,
  output logic                 frame_err,
  output logic [1:0]           err_code,
  output logic                 busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR_H, S_ADDR_L, S_DATA, S_CHK, S_ISSUE
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     tmo_cnt;
  logic [BYTE_SIZE-1:0] acc;
  logic                 we_q;
  logic [BYTE_SIZE-1:0] addr_h_q;
  logic [BYTE_SIZE-1:0] addr_l_q;
  logic [BYTE_SIZE-1:0] data_q;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tmo_cnt   <= '0;
      acc       <= '0;
      we_q      <= 1'b0;
      addr_h_q  <= '0;
      addr_l_q  <= '0;
      data_q    <= '0;
      req_valid <= 1'b0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          // Anything that is not a clean HEADER is line noise.
          if (rx_valid && !rx_parity_err && rx_data == HEADER) begin
            state   <= S_CMD;
            acc     <= '0;
            tmo_cnt <= '0;
          end
        end

        S_CMD, S_ADDR_H, S_ADDR_L, S_DATA, S_CHK: begin
          if (rx_valid) begin
            // A byte arriving in the same cycle as the timeout wins.
            tmo_cnt <= '0;
            if (rx_parity_err) begin
              // Parity is checked before the command or checksum.
              state     <= S_IDLE;
              frame_err <= 1'b1;
              err_code  <= 2'd1;
            end else begin
              case (state)
                S_CMD: begin
                  if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                    we_q  <= (rx_data == CMD_WR);
                    acc   <= acc ^ rx_data;
                    state <= S_ADDR_H;
                  end else begin
                    state     <= S_IDLE;
                    frame_err <= 1'b1;
                    err_code  <= 2'd2;
                  end
                end
                S_ADDR_H: begin
                  addr_h_q <= rx_data;
                  acc      <= acc ^ rx_data;
                  state    <= S_ADDR_L;
                end
                S_ADDR_L: begin
                  addr_l_q <= rx_data;
                  acc      <= acc ^ rx_data;
                  state    <= we_q ? S_DATA : S_CHK;
                end
                S_DATA: begin
                  data_q <= rx_data;
                  acc    <= acc ^ rx_data;
                  state  <= S_CHK;
                end
                S_CHK: begin
                  if (rx_data == acc) begin
                    // Load the request outputs once, here. They stay put
                    // for the whole ISSUE phase.
                    req_valid <= 1'b1;
                    req_we    <= we_q;
                    req_addr  <= 16'({addr_h_q, addr_l_q});
                    req_wdata <= we_q ? data_q : '0;
                    state     <= S_ISSUE;
                  end else begin
                    state     <= S_IDLE;
                    frame_err <= 1'b1;
                    err_code  <= 2'd3;
                  end
                end
                default: state <= S_IDLE;
              endcase
            end
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_cnt   <= '0;
            state     <= S_IDLE;
            frame_err <= 1'b1;
            err_code  <= 2'd0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_ISSUE: begin
          // req_valid is always high here. Bytes that arrive now are
          // dropped, and there is no timeout.
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
